// File: rtl/fc_row_sequencer.sv
// Sequencer for one fully-connected layer: latches an input vector, streams
// weight passes through a shared binary engine, then drains results row by row.
module fc_row_sequencer #(
  parameter  int INPUT_DIM     = 16,
  parameter  int BIT_CNT       = 8,
  parameter  int OUT_ROWS      = 32,
  parameter  int ROWS_PER_PASS = 4,
  localparam int NPASS         = OUT_ROWS / ROWS_PER_PASS,
  localparam int AW            = (NPASS > 1) ? $clog2(NPASS) : 1,
  localparam int IW            = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [INPUT_DIM*BIT_CNT-1:0]       in_data,
  output logic                               w_rd_en,
  output logic [AW-1:0]                      w_addr,
  input  logic [ROWS_PER_PASS*INPUT_DIM-1:0] w_rdata,
  output logic [INPUT_DIM*BIT_CNT-1:0]       eng_value,
  output logic [ROWS_PER_PASS*INPUT_DIM-1:0] eng_weight,
  input  logic [ROWS_PER_PASS*BIT_CNT-1:0]   eng_result,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [BIT_CNT-1:0]                 out_data,
  output logic [IW-1:0]                      out_idx,
  output logic                               busy,
  output logic                               done
);

  // state | meaning
  // IDLE  | waiting for an input vector, in_ready high
  // FETCH | one weight read per cycle, capturing the previous pass
  // FLUSH | capture of the final pass, no read
  // DRAIN | presenting buffered results one row at a time
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  if (OUT_ROWS % ROWS_PER_PASS != 0) begin : g_bad_cfg
    $fatal(1, "fc_row_sequencer: OUT_ROWS must be a multiple of ROWS_PER_PASS");
  end

  state_t                          r_state;
  state_t                          w_next;
  logic [AW-1:0]                   r_addr;
  logic [AW-1:0]                   r_cap_pass;
  logic                            r_cap_valid;
  logic [INPUT_DIM*BIT_CNT-1:0]    r_vec;
  logic [BIT_CNT-1:0]              r_buf [OUT_ROWS];
  logic [IW-1:0]                   r_idx;
  logic                            r_done;

  logic                            w_in_hs;
  logic                            w_last_addr;
  logic                            w_out_hs;
  logic                            w_last_row;

  assign w_in_hs     = (r_state == IDLE) && in_valid;
  assign w_last_addr = (r_addr == AW'(NPASS - 1));
  assign w_out_hs    = (r_state == DRAIN) && out_ready;
  assign w_last_row  = (r_idx == IW'(OUT_ROWS - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = FETCH;
      FETCH:   if (w_last_addr) w_next = FLUSH;
      FLUSH:   w_next = DRAIN;
      DRAIN:   if (out_ready && w_last_row) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_cap_pass  <= '0;
      r_cap_valid <= 1'b0;
      r_vec       <= '0;
      r_idx       <= '0;
      r_done      <= 1'b0;
      for (int i = 0; i < OUT_ROWS; i++) r_buf[i] <= '0;
    end else begin
      r_state     <= w_next;
      r_done      <= w_out_hs && w_last_row;
      r_cap_valid <= (r_state == FETCH);
      r_cap_pass  <= r_addr;

      if (w_in_hs) r_vec <= in_data;

      if (r_state == FETCH) r_addr <= w_last_addr ? '0 : r_addr + 1'b1;

      if (w_out_hs) r_idx <= w_last_row ? '0 : r_idx + 1'b1;

      // Weights read last cycle are on w_rdata now, so the engine result
      // belongs to the pass whose address was issued one cycle earlier.
      for (int p = 0; p < NPASS; p++) begin
        for (int k = 0; k < ROWS_PER_PASS; k++) begin
          if (r_cap_valid && (r_cap_pass == AW'(p)))
            r_buf[p*ROWS_PER_PASS + k] <= eng_result[k*BIT_CNT +: BIT_CNT];
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < OUT_ROWS; i++) begin
      if (r_idx == IW'(i)) out_data = r_buf[i];
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign w_rd_en    = (r_state == FETCH);
  assign w_addr     = r_addr;
  assign eng_value  = r_vec;
  assign eng_weight = w_rdata;
  assign out_valid  = (r_state == DRAIN);
  assign out_idx    = r_idx;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;

endmodule
